// File: rtl/dpram_pipe.sv
// Dual-port RAM (1R/1W) with per-byte write strobes, RD_LATENCY-deep read pipeline
// and a post-reset zero sweep. Optional write-first bypass: DPRAM_PIPE_BYPASS_EN.
module dpram_pipe #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ARVALID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    WVALID,
  input  logic [ADDR_WIDTH-1:0]   WADDR,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    RVALID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    INIT_BUSY,
  output logic                    dbg_state
);

  localparam int SIZE = 1 << ADDR_WIDTH;
  localparam int NB   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;

  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_capture;

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] data_d [RD_LATENCY];

  // Handshake: ARVALID/WVALID are accepted on any edge where INIT_BUSY=0 (no ready,
  // no backpressure); RVALID is a one-cycle pulse per accepted read, RDATA holds otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = WADDR;
    mem_wdata = WDATA;
    mem_be    = WSTRB;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q[ADDR_WIDTH-1:0];
        mem_wdata = '0;
        mem_be    = '1;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we = WVALID;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    rd_accept  = (state_q == ST_RUN) && ARVALID;
    rd_capture = mem[ARADDR];
`ifdef DPRAM_PIPE_BYPASS_EN
    if ((state_q == ST_RUN) && WVALID && (WADDR == ARADDR)) begin
      for (int i = 0; i < NB; i++) begin
        if (WSTRB[i]) rd_capture[8*i +: 8] = WDATA[8*i +: 8];
      end
    end
`endif
  end

  // Data stages only load behind a valid, so the last stage holds the last read word.
  always_comb begin
    vld_d     = '0;
    vld_d[0]  = rd_accept;
    data_d[0] = rd_accept ? rd_capture : data_q[0];
    for (int k = 1; k < RD_LATENCY; k++) begin
      vld_d[k]  = vld_q[k-1];
      data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int k = 0; k < RD_LATENCY; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      for (int k = 0; k < RD_LATENCY; k++) data_q[k] <= data_d[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign RVALID    = vld_q[RD_LATENCY-1];
  assign RDATA     = data_q[RD_LATENCY-1];
  assign INIT_BUSY = (state_q == ST_INIT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dpram_pipe.sv
// Bench for dpram_pipe: latency-1 and latency-3 instances share stimulus; a monitor
// checks each RVALID against queued expectations and arrival cycle.
module tb_dpram_pipe;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int NB = DW / 8;

`ifdef DPRAM_PIPE_BYPASS_EN
  localparam logic [DW-1:0] RW7_EXP = 64'h0000_0000_0000_DEAD;
  localparam logic [DW-1:0] RW2_EXP = 64'hAAAA_AAAA_FFFF_FFFF;
`else
  localparam logic [DW-1:0] RW7_EXP = 64'h0;
  localparam logic [DW-1:0] RW2_EXP = 64'h1122_3344_FFFF_FFFF;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          arvalid = 1'b0;
  logic [AW-1:0] araddr  = '0;
  logic          wvalid  = 1'b0;
  logic [AW-1:0] waddr   = '0;
  logic [DW-1:0] wdata   = '0;
  logic [NB-1:0] wstrb   = '0;

  logic          rvalid1, busy1, dbg1;
  logic [DW-1:0] rdata1;
  logic          rvalid3, busy3, dbg3;
  logic [DW-1:0] rdata3;

  dpram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_lat1 (
    .CLK(clk), .RESET(rst), .ARVALID(arvalid), .ARADDR(araddr),
    .WVALID(wvalid), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb),
    .RVALID(rvalid1), .RDATA(rdata1), .INIT_BUSY(busy1), .dbg_state(dbg1)
  );

  dpram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_lat3 (
    .CLK(clk), .RESET(rst), .ARVALID(arvalid), .ARADDR(araddr),
    .WVALID(wvalid), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb),
    .RVALID(rvalid3), .RDATA(rdata3), .INIT_BUSY(busy3), .dbg_state(dbg3)
  );

  // scoreboard
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q3[$];
  int            t_q1[$];
  int            t_q3[$];
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid1 === 1'b1) begin
      if (exp_q1.size() == 0) chk("lat1_unexpected_rvalid", 64'd1, 64'd0);
      else begin
        chk("lat1_rdata", rdata1, exp_q1.pop_front());
        chk("lat1_latency", 64'(cyc), 64'(t_q1.pop_front() + 1));
      end
    end
    if (rvalid3 === 1'b1) begin
      if (exp_q3.size() == 0) chk("lat3_unexpected_rvalid", 64'd1, 64'd0);
      else begin
        chk("lat3_rdata", rdata3, exp_q3.pop_front());
        chk("lat3_latency", 64'(cyc), 64'(t_q3.pop_front() + 3));
      end
    end
  end

  // driver tasks
  task automatic drive(input logic rv, input logic [AW-1:0] ra, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] ws, input logic [DW-1:0] exp);
    @(posedge clk);
    #1;
    arvalid = rv; araddr = ra;
    wvalid  = wv; waddr  = wa; wdata = wd; wstrb = ws;
    if (rv) begin
      exp_q1.push_back(exp); t_q1.push_back(cyc);
      exp_q3.push_back(exp); t_q3.push_back(cyc);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(1'b1, a, 1'b0, '0, '0, '0, exp);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    drive(1'b0, '0, 1'b1, a, d, s, '0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
    repeat (n) @(posedge clk);
  endtask

  // Counts sampled INIT_BUSY-high cycles; optionally pokes requests that must be dropped.
  task automatic wait_init(input bit poke, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy1 !== 1'b1) break;
      n++;
      if (poke && n == 1) begin
        arvalid = 1'b1; araddr = 4'd3;
        wvalid  = 1'b1; waddr  = 4'd3; wdata = 64'hAA; wstrb = '1;
      end
      if (poke && n == 6) begin
        arvalid = 1'b0; wvalid = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    #23;
    chk("reset_rvalid1", 64'(rvalid1), 64'd0);
    chk("reset_rvalid3", 64'(rvalid3), 64'd0);
    chk("reset_rdata1", rdata1, 64'd0);
    chk("reset_rdata3", rdata3, 64'd0);
    chk("reset_busy", 64'(busy1), 64'd1);
    chk("reset_dbg_state", 64'(dbg1), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    wait_init(1'b1, n);
    chk("init_cycles", 64'(n), 64'd16);
    chk("init_busy3_low", 64'(busy3), 64'd0);
    chk("run_dbg_state", 64'(dbg3), 64'd1);

    rd(4'd5, 64'h0);
    rd(4'd3, 64'h0);
    idle(5);

    wr(4'd2, 64'h1122_3344_5566_7788, 8'hFF);
    repeat (4) rd(4'd2, 64'h1122_3344_5566_7788);
    idle(6);
    chk("hold_rvalid1", 64'(rvalid1), 64'd0);
    chk("hold_rdata1", rdata1, 64'h1122_3344_5566_7788);
    chk("hold_rdata3", rdata3, 64'h1122_3344_5566_7788);

    wr(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    rd(4'd2, 64'h1122_3344_FFFF_FFFF);
    drive(1'b1, 4'd7, 1'b1, 4'd7, 64'hDEAD, 8'h03, RW7_EXP);
    rd(4'd7, 64'hDEAD);
    drive(1'b1, 4'd2, 1'b1, 4'd2, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0, RW2_EXP);
    rd(4'd2, 64'hAAAA_AAAA_FFFF_FFFF);
    drive(1'b1, 4'd7, 1'b1, 4'd5, 64'h55, 8'h01, 64'hDEAD);
    rd(4'd5, 64'h55);
    rd(4'd5, 64'h55);
    wr(4'd5, 64'h66, 8'h01);
    rd(4'd5, 64'h66);
    wr(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    rd(4'd7, 64'hDEAD);
    idle(6);

    rd(4'd2, 64'hAAAA_AAAA_FFFF_FFFF);
    rd(4'd5, 64'h66);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst = 1'b1;
    exp_q1.delete(); t_q1.delete();
    exp_q3.delete(); t_q3.delete();
    #1;
    chk("midreset_rvalid1", 64'(rvalid1), 64'd0);
    chk("midreset_rvalid3", 64'(rvalid3), 64'd0);
    chk("midreset_busy", 64'(busy3), 64'd1);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    wait_init(1'b0, n);
    chk("reinit_cycles", 64'(n), 64'd16);

    rd(4'd2, 64'h0);
    rd(4'd5, 64'h0);
    idle(1);
    for (int i = 0; i < 20; i++) begin
      if (exp_q1.size() == 0 && exp_q3.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_lat1", 64'(exp_q1.size()), 64'd0);
    chk("drain_lat3", 64'(exp_q3.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_pipe.md
Name: dpram_pipe

Overview:
Parametrised dual-port RAM (one read port, one write port) that replaces the read-stub RAM used in buffet datapaths. It has real storage, per-byte write strobes, and a configurable read-pipeline latency. After reset it runs a hardware zero-initialisation sweep, so buffet control logic always sees deterministic contents. It sits directly under the buffet storage controller.

Parameters:
ADDR_WIDTH, 10, address width; depth SIZE = 2**ADDR_WIDTH words
DATA_WIDTH, 64, word width in bits; must be a multiple of 8
RD_LATENCY, 1, cycles from read accept to RVALID; legal range 1..4

Ports:
CLK  input  1  clock; all logic on rising edge
RESET  input  1  asynchronous, active-high reset
ARVALID  input  1  read request; accepted when INIT_BUSY=0
ARADDR  input  ADDR_WIDTH  read word address
WVALID  input  1  write request; accepted when INIT_BUSY=0
WADDR  input  ADDR_WIDTH  write word address
WDATA  input  DATA_WIDTH  write data
WSTRB  input  DATA_WIDTH/8  byte enables; bit i covers WDATA[8i+7:8i]
RVALID  output  1  read data valid, one-cycle pulse per accepted read
RDATA  output  DATA_WIDTH  read data
INIT_BUSY  output  1  high while the zero sweep runs; requests are ignored

Behaviour:
- Reset is asynchronous and active-high on RESET; the block runs on the single clock CLK.
- Reset values:
  - RVALID=0, RDATA=0, INIT_BUSY=1.
  - Read pipeline valid bits cleared.
  - Sweep counter=0, state=INIT.
  - Memory contents are not reset directly; the sweep clears them.
- State machine:
  - INIT: each cycle writes zero to mem[cnt], then cnt+1. When cnt==SIZE-1 is written, go to RUN.
  - INIT therefore lasts exactly SIZE cycles after RESET deasserts. INIT_BUSY=1 throughout INIT.
  - RUN: INIT_BUSY=0. Only a reset leaves RUN.
- Requests during INIT:
  - ARVALID is dropped; no RVALID is ever produced for it.
  - WVALID is dropped; memory holds the sweep value.
- Write (RUN): on the edge with WVALID=1, mem[WADDR] byte i <= WDATA byte i for each WSTRB[i]=1.
  - Bytes with WSTRB[i]=0 are unchanged.
  - WSTRB=0 is a legal no-op.
- Read (RUN):
  - ARVALID=1 at edge T samples mem[ARADDR] into stage 1.
  - Data moves one stage per cycle. RVALID=1 and RDATA=data during the cycle after edge T+RD_LATENCY-1, i.e. RD_LATENCY cycles after the request cycle.
  - Fully pipelined: one read per cycle, back-to-back reads give back-to-back RVALID pulses.
  - There is no backpressure.
- RDATA holds its last value while RVALID=0; it is not cleared.
- In-flight reads are snapshots taken at issue. A later write to the same address does not alter data already in the pipeline.
- Same-cycle read and write to the same address: read-first (old data), unless the bypass feature is enabled.
- Same-cycle read and write to different addresses: fully independent.
- Reset mid-operation:
  - In-flight reads are discarded; RVALID=0 immediately, asynchronously.
  - The sweep restarts at address 0.
- Address arithmetic: sweep counter is ADDR_WIDTH+1 bits, so termination has no wrap ambiguity. Address ports are used unmodified; no bounds check is needed because the address covers the full depth.

Optional Feature:
Macro DPRAM_PIPE_BYPASS_EN.
- Defined: on a same-cycle read and write to the same address in RUN, the captured read data is write-first. Strobed bytes come from WDATA; unstrobed bytes come from old mem contents. The merge is per byte.
- Undefined: read-first; the captured data is the full old word.
- The macro has no effect on any other behaviour or timing.

Test Plan:
- Reset then idle, RD_LATENCY=1, ADDR_WIDTH=4 -> INIT_BUSY high for exactly 16 cycles after RESET falls. Then read addr 5 -> RVALID 1 cycle later, RDATA=0.
- During INIT: write addr 3 = 0xAA and read addr 3 -> no RVALID. After INIT, read addr 3 -> RDATA=0.
- RUN, RD_LATENCY=3: write addr 2 = 0x1122334455667788 with WSTRB=0xFF. Then read addr 2 for 4 consecutive cycles -> 4 consecutive RVALID pulses starting 3 cycles after the first read, all RDATA=0x1122334455667788.
- Partial write: WSTRB=0x0F, WDATA=0xFFFFFFFFFFFFFFFF to addr 2 (holding 0x1122334455667788). Then read -> RDATA=0x11223344FFFFFFFF.
- Same-cycle read+write addr 7 (old 0x0, new 0xDEAD, WSTRB=0x03) -> RDATA=0x0 without DPRAM_PIPE_BYPASS_EN, RDATA=0xDEAD with it. A following read returns 0xDEAD in both builds.
- RESET asserted while 2 reads are in flight (RD_LATENCY=3) -> RVALID stays 0, and no stale pulse appears after RESET falls. INIT_BUSY=1 again and the sweep restarts at 0.
